// File: rtl/dm_sba_ext_if.sv
// System-bus master port of the debug-module SBA engine: request side driven
// by the engine, grant/response side driven by the bus.
interface dm_sba_ext_if #(
  parameter int BusWidth = 32
);
  logic                  master_req_o;
  logic                  master_we_o;
  logic [BusWidth-1:0]   master_add_o;
  logic [BusWidth-1:0]   master_wdata_o;
  logic [BusWidth/8-1:0] master_be_o;
  logic                  master_gnt_i;
  logic                  master_r_valid_i;
  logic                  master_r_err_i;
  logic [BusWidth-1:0]   master_r_rdata_i;

  modport master (
    output master_req_o, master_we_o, master_add_o, master_wdata_o, master_be_o,
    input  master_gnt_i, master_r_valid_i, master_r_err_i, master_r_rdata_i
  );

  modport slave (
    input  master_req_o, master_we_o, master_add_o, master_wdata_o, master_be_o,
    output master_gnt_i, master_r_valid_i, master_r_err_i, master_r_rdata_i
  );
endinterface

// File: rtl/dm_sba_ext.sv
// Debug-module system bus access engine: turns sbaddress/sbdata requests into
// single bus transfers with size/alignment checks, timeout and autoincrement.
module dm_sba_ext #(
  parameter int BusWidth      = 32,
  parameter int TimeoutCycles = 255
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                dmactive_i,
  dm_sba_ext_if.master        bus,
  input  logic [BusWidth-1:0] sbaddress_i,
  input  logic                sbaddress_write_valid_i,
  input  logic                sbreadonaddr_i,
  input  logic                sbautoincrement_i,
  input  logic                sbreadondata_i,
  input  logic                sbdata_read_valid_i,
  input  logic                sbdata_write_valid_i,
  input  logic [2:0]          sbaccess_i,
  input  logic [BusWidth-1:0] sbdata_i,
  output logic [BusWidth-1:0] sbaddress_o,
  output logic [BusWidth-1:0] sbdata_o,
  output logic                sbdata_valid_o,
  output logic                sbbusy_o,
  output logic                sberror_valid_o,
  output logic [2:0]          sberror_o
);
  localparam int BeW  = BusWidth / 8;
  localparam int OffW = $clog2(BeW);
  localparam int CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [2:0]      MaxSize = 3'(OffW);
  localparam logic [CntW-1:0] CntMax  = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);

  typedef enum logic [2:0] {IDLE, READ, WRITE, WAIT_READ, WAIT_WRITE} state_e;

  state_e              state_q, state_d;
  logic [BusWidth-1:0] addr_q, addr_d, wdata_q, wdata_d, sbdata_q, sbdata_d;
  logic [2:0]          size_q, size_d, sberror_q, sberror_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                dvalid_q, dvalid_d, evalid_q, evalid_d;
  logic [OffW-1:0]     offset;
  logic [BusWidth-1:0] rdata_shifted, rdata_masked;
  logic                start_rd, start_wr, misaligned, active, waiting, complete_ok;

  // Read-on-data outranks a write, which outranks read-on-address.
  assign start_rd   = (sbdata_read_valid_i && sbreadondata_i) ||
                      (!sbdata_write_valid_i && sbaddress_write_valid_i && sbreadonaddr_i);
  assign start_wr   = sbdata_write_valid_i && !(sbdata_read_valid_i && sbreadondata_i);
  assign misaligned = (sbaddress_i[OffW-1:0] & OffW'((1 << sbaccess_i) - 1)) != '0;

  assign offset      = addr_q[OffW-1:0];
  assign active      = (state_q == READ) || (state_q == WRITE);
  assign waiting     = (state_q == WAIT_READ) || (state_q == WAIT_WRITE);
  assign complete_ok = waiting && bus.master_r_valid_i && !bus.master_r_err_i;

  assign sbbusy_o        = (state_q != IDLE);
  assign sbdata_o        = sbdata_q;
  assign sbdata_valid_o  = dvalid_q;
  assign sberror_valid_o = evalid_q;
  assign sberror_o       = sberror_q;
  assign sbaddress_o     = (complete_ok && sbautoincrement_i) ?
                           sbaddress_i + (BusWidth'(1) << size_q) : sbaddress_i;

  always_comb begin
    bus.master_req_o   = active;
    bus.master_we_o    = (state_q == WRITE);
    bus.master_add_o   = '0;
    bus.master_wdata_o = '0;
    bus.master_be_o    = '0;
    if (active) bus.master_add_o = {addr_q[BusWidth-1:OffW], {OffW{1'b0}}};
    if (state_q == WRITE) begin
      bus.master_wdata_o = wdata_q << {offset, 3'b000};
      for (int i = 0; i < BeW; i++)
        bus.master_be_o[i] = (i >= int'(offset)) && (i < int'(offset) + (1 << size_q));
    end
  end

  // Align the addressed lane down to bit 0 and keep only the accessed bytes.
  always_comb begin
    rdata_shifted = bus.master_r_rdata_i >> {offset, 3'b000};
    rdata_masked  = '0;
    for (int i = 0; i < BeW; i++)
      if (i < (1 << size_q)) rdata_masked[8*i +: 8] = rdata_shifted[8*i +: 8];
  end

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    sbdata_d  = sbdata_q;
    cnt_d     = cnt_q;
    sberror_d = sberror_q;
    dvalid_d  = 1'b0;
    evalid_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_rd || start_wr) begin
          addr_d  = sbaddress_i;
          size_d  = sbaccess_i;
          wdata_d = sbdata_i;
          if (sbaccess_i > MaxSize) begin
            evalid_d  = 1'b1;
            sberror_d = 3'd4;
          end else if (misaligned) begin
            evalid_d  = 1'b1;
            sberror_d = 3'd3;
          end else begin
            state_d = start_rd ? READ : WRITE;
          end
        end
      end
      READ, WRITE: begin
        if (bus.master_gnt_i) begin
          state_d = (state_q == READ) ? WAIT_READ : WAIT_WRITE;
          cnt_d   = '0;
        end
      end
      WAIT_READ, WAIT_WRITE: begin
        if (bus.master_r_valid_i) begin
          state_d = IDLE;
          if (bus.master_r_err_i) begin
            evalid_d  = 1'b1;
            sberror_d = 3'd2;
          end else if (state_q == WAIT_READ) begin
            sbdata_d = rdata_masked;
            dvalid_d = 1'b1;
          end
        end else if (TimeoutCycles != 0) begin
          if (cnt_q == CntMax) begin
            state_d   = IDLE;
            evalid_d  = 1'b1;
            sberror_d = 3'd1;
          end else begin
            cnt_d = cnt_q + CntW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Dropping dmactive silently abandons whatever is in flight.
    if (!dmactive_i) begin
      state_d   = IDLE;
      addr_d    = '0;
      size_d    = '0;
      wdata_d   = '0;
      sbdata_d  = '0;
      cnt_d     = '0;
      sberror_d = '0;
      dvalid_d  = 1'b0;
      evalid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      size_q    <= '0;
      wdata_q   <= '0;
      sbdata_q  <= '0;
      cnt_q     <= '0;
      sberror_q <= '0;
      dvalid_q  <= 1'b0;
      evalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      sbdata_q  <= sbdata_d;
      cnt_q     <= cnt_d;
      sberror_q <= sberror_d;
      dvalid_q  <= dvalid_d;
      evalid_q  <= evalid_d;
    end
  end
endmodule

// File: doc/dm_sba_ext.md
DM_SBA_EXT -- requirements
Module: dm_sba_ext

Interface
REQ-001 SHALL have parameter BusWidth, default 32, bus data/address width; only 32 and 64 are legal.
REQ-002 SHALL have parameter TimeoutCycles, default 255, wait-state cycles before timeout; 0 disables timeout.
REQ-003 SHALL have clk_i  in  1  sole clock, rising edge.
REQ-004 SHALL have rst_ni  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have dmactive_i  in  1  synchronous clear, active-low.
REQ-006 SHALL have master_req_o / master_we_o  out  1; master_add_o, master_wdata_o  out  BusWidth; master_be_o  out  BusWidth/8; these are the bus request, write flag, address, write data and byte enables.
REQ-007 SHALL have master_gnt_i, master_r_valid_i, master_r_err_i  in  1; master_r_rdata_i  in  BusWidth; these are the grant, response valid, response error and read data.
REQ-008 SHALL have sbaddress_i  in  BusWidth; sbaddress_write_valid_i, sbreadonaddr_i, sbautoincrement_i, sbreadondata_i, sbdata_read_valid_i, sbdata_write_valid_i  in  1; sbaccess_i  in  3; sbdata_i  in  BusWidth.
REQ-009 SHALL have sbaddress_o, sbdata_o  out  BusWidth; sbdata_valid_o, sbbusy_o, sberror_valid_o  out  1; sberror_o  out  3.

Function
REQ-010 States: Idle, Read, Write, WaitRead, WaitWrite; sbbusy_o = (state != Idle).
REQ-011 Idle start-request priority, highest first: sbdata_read_valid_i&&sbreadondata_i (read); sbdata_write_valid_i (write); sbaddress_write_valid_i&&sbreadonaddr_i (read).
REQ-012 On start, SHALL latch addr_q=sbaddress_i, size_q=sbaccess_i, wdata_q=sbdata_i; later input changes do not affect the transfer.
REQ-013 On start, size check: size_q > log2(BusWidth/8) -> no bus request, stay Idle, sberror_valid_o pulse 1 cycle next cycle, sberror_o=4.
REQ-014 Alignment check, applied only if the size check passes: addr_q not a multiple of 2^size_q -> same behaviour as REQ-013, but sberror_o=3.
REQ-015 Read/Write: master_req_o=1, master_add_o={addr_q upper bits, offset zeroed}, i.e. word-aligned; Write adds master_we_o=1; on master_gnt_i, go to WaitRead/WaitWrite next cycle.
REQ-016 Byte enables: bits [offset +: 2^size_q] set, all others 0, where offset = addr_q[log2(BusWidth/8)-1:0]; master_be_o=0 when not writing.
REQ-017 master_wdata_o = wdata_q shifted left by 8*offset; master_wdata_o=0 when not writing.
REQ-018 Wait states: on master_r_valid_i, return to Idle next cycle; master_r_valid_i outside Wait states SHALL be ignored.
REQ-019 Read completion without error: sbdata_o <= (master_r_rdata_i >> 8*offset), with bytes above 2^size_q zeroed; sbdata_valid_o pulses 1 cycle, registered (one cycle after master_r_valid_i).
REQ-020 Write completion without error SHALL NOT pulse sbdata_valid_o.
REQ-021 Completion with master_r_err_i=1: sberror_valid_o pulse, registered, sberror_o=2; no data valid; no address increment.
REQ-022 Timeout counter: cleared on entry to a Wait state, increments each Wait cycle without master_r_valid_i; on reaching TimeoutCycles -> Idle, sberror_valid_o pulse, sberror_o=1; a later stray response is ignored.
REQ-023 sbaddress_o = sbaddress_i, except in the completion cycle of a successful access with sbautoincrement_i=1: sbaddress_i + (1 << size_q), wrapping modulo 2^BusWidth.
REQ-024 sbdata_o holds its last value between reads.
REQ-025 Start requests arriving while not Idle SHALL be ignored.

Reset
REQ-026 On rst_ni low, asynchronously: state=Idle; counter=0; addr_q, size_q, wdata_q, sbdata_o=0; sbdata_valid_o=0; sberror_valid_o=0; sberror_o=0; all master_* outputs=0.
REQ-027 dmactive_i=0 SHALL apply the same values synchronously on the next edge, aborting any in-flight transfer without an error pulse.

Verification
REQ-028 BusWidth=32: sbdata_write_valid_i, addr=0x1002, sbaccess=1, sbdata=0xBEEF -> master_add_o=0x1000, be=4'b1100, wdata=0xBEEF0000; gnt, then r_valid -> Idle, no sbdata_valid_o.
REQ-029 BusWidth=64: read-on-addr at 0x2004, sbaccess=2, autoincrement=1, rdata=0x11223344_55667788 -> sbdata_o=0x11223344 one cycle after r_valid; sbaddress_o=0x2008 in the completion cycle.
REQ-030 sbaccess=3 with BusWidth=32 -> no master_req_o, sberror_o=4 pulse; addr=0x3 with sbaccess=1 -> sberror_o=3 pulse.
REQ-031 TimeoutCycles=4, grant given, no response -> Idle after 4 wait cycles, sberror_o=1; a late r_valid produces no sbdata_valid_o.
REQ-032 Write and read-on-data requested in the same Idle cycle -> read is performed; r_err during read -> sberror_o=2, address unchanged.
REQ-033 dmactive_i dropped while in WaitRead -> Idle next cycle, no error pulse; rst_ni asserted mid-Write -> master_req_o=0 immediately.
